// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if: fetch, loader and instruction-memory signals shared by the port arbiter.
interface imem_port_arbiter_if;
  logic        f_req, f_gnt, f_rsp_valid, f_rsp_err;
  logic [31:0] f_addr, f_rsp_data;
  logic        l_req, l_we, l_lock, l_gnt, l_rsp_valid, l_rsp_err;
  logic [31:0] l_addr, l_wdata, l_rsp_data;
  logic        mem_read_write;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_data_out,
    input  f_gnt, f_rsp_valid, f_rsp_data, f_rsp_err,
    input  l_gnt, l_rsp_valid, l_rsp_data, l_rsp_err,
    input  mem_read_write, mem_address, mem_data_in
  );
  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_data_out,
    output f_gnt, f_rsp_valid, f_rsp_data, f_rsp_err,
    output l_gnt, l_rsp_valid, l_rsp_data, l_rsp_err,
    output mem_read_write, mem_address, mem_data_in
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: round-robin fetch/loader arbiter for the instruction-memory port.
// Define IMEM_ARB_LOCK_EN to let the loader hold the port exclusively via l_lock.
module imem_port_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  imem_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0]   conflict_cnt_o
);
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(MEM_BYTES) - 32'd4;
  typedef enum logic {ARB, LOCKED} state_e;
  state_e state_q, state_d;
  logic last_q, last_d;  // 1: loader holds the most recent grant
  logic f_valid_q, f_valid_d, f_err_q, f_err_d;
  logic l_valid_q, l_valid_d, l_err_q, l_err_d;
  logic [31:0] f_data_q, f_data_d, l_data_q, l_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic locked, f_bad, l_bad, f_gnt, l_gnt;
  function automatic logic addr_bad(input logic [31:0] a);
    return (a < BASE_ADDR) || (a > LAST_ADDR) || (a[1:0] != 2'b00);
  endfunction
  always_comb begin
    locked    = state_q == LOCKED;
    f_bad     = addr_bad(bus.f_addr);
    l_bad     = addr_bad(bus.l_addr);
    f_gnt     = bus.f_req & ~locked & (~bus.l_req | last_q);
    l_gnt     = bus.l_req & (locked | ~bus.f_req | ~last_q);
    last_d    = f_gnt ? 1'b0 : l_gnt ? 1'b1 : last_q;
    cnt_d     = (bus.f_req & bus.l_req & ~locked & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    f_valid_d = f_gnt;
    f_err_d   = f_gnt & f_bad;
    f_data_d  = (f_gnt & ~f_bad) ? bus.mem_data_out : '0;
    l_valid_d = l_gnt;
    l_err_d   = l_gnt & l_bad;
    l_data_d  = (l_gnt & ~l_bad & ~bus.l_we) ? bus.mem_data_out : '0;
`ifdef IMEM_ARB_LOCK_EN
    state_d   = locked ? (bus.l_lock ? LOCKED : ARB) : ((l_gnt & bus.l_lock) ? LOCKED : ARB);
`else
    state_d   = ARB;
`endif
  end
`ifndef IMEM_ARB_LOCK_EN
  logic lock_unused;
  assign lock_unused = bus.l_lock;
`endif
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q   <= ARB;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      f_valid_q <= 1'b0;
      f_err_q   <= 1'b0;
      f_data_q  <= '0;
      l_valid_q <= 1'b0;
      l_err_q   <= 1'b0;
      l_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      f_valid_q <= f_valid_d;
      f_err_q   <= f_err_d;
      f_data_q  <= f_data_d;
      l_valid_q <= l_valid_d;
      l_err_q   <= l_err_d;
      l_data_q  <= l_data_d;
    end
  assign bus.f_gnt          = f_gnt;
  assign bus.l_gnt          = l_gnt;
  assign bus.f_rsp_valid    = f_valid_q;
  assign bus.f_rsp_data     = f_data_q;
  assign bus.f_rsp_err      = f_err_q;
  assign bus.l_rsp_valid    = l_valid_q;
  assign bus.l_rsp_data     = l_data_q;
  assign bus.l_rsp_err      = l_err_q;
  assign bus.mem_address    = f_gnt ? bus.f_addr : l_gnt ? bus.l_addr : BASE_ADDR;
  assign bus.mem_data_in    = (f_gnt | l_gnt) ? bus.l_wdata : '0;
  assign bus.mem_read_write = l_gnt & bus.l_we & ~l_bad;
  assign conflict_cnt_o     = cnt_q;
endmodule
